// File: rtl/e1_wb_tx_bdctl_pkg.sv
// Shared definitions for the E1 TX buffer-descriptor controller: address decode,
// CSR/status bit map, BD word layout and the channel mode encoding.
package e1_wb_tx_bdctl_pkg;

   localparam logic ADDR_CSR = 1'b0;
   localparam logic ADDR_BD  = 1'b1;

   localparam int CSR_ENABLE     = 0;
   localparam int CSR_MODE_LSB   = 1;
   localparam int CSR_TIME_SRC   = 3;
   localparam int CSR_ALARM      = 4;
   localparam int CSR_LOOP_LSB   = 5;
   localparam int CSR_IRQ_EN_BDO = 8;
   localparam int CSR_IRQ_EN_ERR = 9;
   localparam int CSR_CLR_UNDER  = 12;
   localparam int CSR_CLR_OVER   = 13;

   localparam int ST_ENABLED   = 0;
   localparam int ST_BTI_EMPTY = 1;
   localparam int ST_BTI_FULL  = 2;
   localparam int ST_BTO_EMPTY = 3;
   localparam int ST_BTO_FULL  = 4;
   localparam int ST_UNDER     = 5;
   localparam int ST_OVER      = 6;
   localparam int ST_LEVEL_LSB = 8;
   localparam int ST_UCNT_LSB  = 12;

   localparam int BD_CRC_LSB   = 13;
   localparam int BD_LEVEL_LSB = 8;
   localparam int BD_VALID_BIT = 15;

   typedef enum logic [1:0] {
      MODE_TRANSPARENT = 2'b00,
      MODE_FRAMED      = 2'b01,
      MODE_CRC4        = 2'b10,
      MODE_CRC4_AUTO   = 2'b11
   } e1_mode_e;

   // Underflow counter sticks at 15 rather than wrapping back to a small value.
   function automatic logic [3:0] satInc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/e1_bd_fifo.sv
// Small synchronous FIFO holding buffer descriptors; reports level, empty and full.
// A push into a full FIFO only succeeds when a pop frees the slot in the same cycle.
module e1_bd_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      level_q, level_d;
   logic             doPush, doPop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign doPop   = pop_i & ~empty_o;
   assign doPush  = push_i & (~full_o | doPop);
   assign level_d = level_q + (AW+1)'(doPush) - (AW+1)'(doPop);
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (doPush) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (doPop) rptr_q <= rptr_q + 1'b1;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/e1_wb_tx_bdctl.sv
// Bus-side control for NCH E1 transmitters: per-channel CSR, BD-in queue feeding the
// TX core, BD-out queue of completed descriptors, underflow/overflow stickies and irqs.
module e1_wb_tx_bdctl #(
   parameter int NCH      = 4,
   parameter int MFW      = 7,
   parameter int BD_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bus_addr_sel,
   input  logic [3:0]         bus_addr,
   input  logic [15:0]        bus_wdata,
   output logic [15:0]        bus_rdata,
   input  logic               bus_clr,
   input  logic               bus_we,
   output logic [NCH*MFW-1:0] bd_mf,
   output logic [2*NCH-1:0]   bd_crc_e,
   output logic [NCH-1:0]     bd_valid,
   input  logic [NCH-1:0]     bd_done,
   input  logic [NCH-1:0]     bd_miss,
   output logic [NCH-1:0]     ctrl_enabled,
   output logic [NCH-1:0]     ctrl_rst,
   output logic [2*NCH-1:0]   ctrl_mode,
   output logic [NCH-1:0]     ctrl_time_src,
   output logic [NCH-1:0]     ctrl_alarm,
   output logic [2*NCH-1:0]   ctrl_loopback,
   input  logic [2*NCH-1:0]   crc_e_auto,
   output logic [NCH-1:0]     crc_e_ack,
   output logic [NCH-1:0]     irq,
   output logic               irq_any
);
   import e1_wb_tx_bdctl_pkg::*;

   localparam int LW = $clog2(BD_DEPTH) + 1;
   localparam int BW = MFW + 2;

   logic [15:0]    csrRdArr [NCH];
   logic [15:0]    bdRdArr  [NCH];
   logic [NCH-1:0] btiFullV, btoEmptyV;
   logic [15:0]    selRdata;
   logic           selBtiFull, selBtoEmpty, chHit, busGo;
   logic           csrWr_d, bdPush_d, bdPop_d;
   logic           csrWr_q, bdPush_q, bdPop_q;
   logic [2:0]     ch_q;
   logic [15:0]    wdata_q;
   logic           unusedWdata;

   // Combinational decode of the live bus address; also samples full/empty at strobe time.
   always_comb begin
      selRdata    = '0;
      selBtiFull  = 1'b0;
      selBtoEmpty = 1'b1;
      chHit       = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (bus_addr[3:1] == 3'(i)) begin
            chHit       = 1'b1;
            selRdata    = (bus_addr[0] == ADDR_BD) ? bdRdArr[i] : csrRdArr[i];
            selBtiFull  = btiFullV[i];
            selBtoEmpty = btoEmptyV[i];
         end
      end
   end

   assign bus_rdata = bus_addr_sel ? selRdata : 16'h0000;

   assign busGo    = bus_addr_sel & ~bus_clr & chHit;
   assign csrWr_d  = busGo & bus_we & (bus_addr[0] == ADDR_CSR);
   assign bdPush_d = busGo & bus_we & (bus_addr[0] == ADDR_BD) & ~selBtiFull;
   assign bdPop_d  = busGo & ~bus_we & (bus_addr[0] == ADDR_BD) & ~selBtoEmpty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csrWr_q  <= 1'b0;
         bdPush_q <= 1'b0;
         bdPop_q  <= 1'b0;
         ch_q     <= '0;
         wdata_q  <= '0;
      end else begin
         csrWr_q  <= csrWr_d;
         bdPush_q <= bdPush_d;
         bdPop_q  <= bdPop_d;
         ch_q     <= bus_addr[3:1];
         wdata_q  <= bus_wdata;
      end
   end

   assign unusedWdata = ^wdata_q;
   assign crc_e_ack   = bd_done;
   assign irq_any     = |irq;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic           hit, csrWr, btiPush, btoPop, btiPop, btoPush, ovfSet;
      logic           en_q, tsrc_q, alarm_q, irqBdo_q, irqErr_q, crst_q;
      logic           und_q, und_d, ovf_q, ovf_d;
      logic [3:0]     ucnt_q, ucnt_d;
      logic [1:0]     lb_q;
      e1_mode_e       mode_q;
      logic [BW-1:0]  btiHead;
      logic [MFW-1:0] btoHead;
      logic           btiEmpty, btiFull, btoEmpty, btoFull;
      logic [LW-1:0]  btiLvl, btoLvl;
      logic [15:0]    csrRd, bdRd;

      assign hit     = (ch_q == 3'(c));
      assign csrWr   = csrWr_q & hit;
      assign btiPush = bdPush_q & hit;
      assign btoPop  = bdPop_q & hit;
      // A completed BD moves to BD-out unless that queue is full with no bus pop freeing a slot.
      assign btiPop  = bd_done[c] & ~btiEmpty;
      assign btoPush = btiPop & (~btoFull | btoPop);
      assign ovfSet  = btiPop & btoFull & ~btoPop;

      e1_bd_fifo #(.WIDTH(BW), .DEPTH(BD_DEPTH)) u_bti (
         .clk     (clk),
         .rst     (rst),
         .push_i  (btiPush),
         .wdata_i ({wdata_q[BD_CRC_LSB +: 2], wdata_q[MFW-1:0]}),
         .pop_i   (btiPop),
         .rdata_o (btiHead),
         .empty_o (btiEmpty),
         .full_o  (btiFull),
         .level_o (btiLvl)
      );

      e1_bd_fifo #(.WIDTH(MFW), .DEPTH(BD_DEPTH)) u_bto (
         .clk     (clk),
         .rst     (rst),
         .push_i  (btoPush),
         .wdata_i (btiHead[MFW-1:0]),
         .pop_i   (btoPop),
         .rdata_o (btoHead),
         .empty_o (btoEmpty),
         .full_o  (btoFull),
         .level_o (btoLvl)
      );

      // A miss in the same cycle as a software clear wins, so the event is never lost.
      always_comb begin
         und_d  = und_q;
         ucnt_d = ucnt_q;
         ovf_d  = ovf_q;
         if (csrWr && wdata_q[CSR_CLR_UNDER]) begin
            und_d  = 1'b0;
            ucnt_d = 4'd0;
         end
         if (bd_miss[c]) begin
            und_d  = 1'b1;
            ucnt_d = satInc4(ucnt_d);
         end
         if (csrWr && wdata_q[CSR_CLR_OVER]) ovf_d = 1'b0;
         if (ovfSet) ovf_d = 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            en_q     <= 1'b0;
            mode_q   <= MODE_TRANSPARENT;
            tsrc_q   <= 1'b0;
            alarm_q  <= 1'b0;
            lb_q     <= 2'b00;
            irqBdo_q <= 1'b0;
            irqErr_q <= 1'b0;
            und_q    <= 1'b0;
            ucnt_q   <= 4'd0;
            ovf_q    <= 1'b0;
            crst_q   <= 1'b1;
         end else begin
            if (csrWr) begin
               en_q     <= wdata_q[CSR_ENABLE];
               mode_q   <= e1_mode_e'(wdata_q[CSR_MODE_LSB +: 2]);
               tsrc_q   <= wdata_q[CSR_TIME_SRC];
               alarm_q  <= wdata_q[CSR_ALARM];
               lb_q     <= wdata_q[CSR_LOOP_LSB +: 2];
               irqBdo_q <= wdata_q[CSR_IRQ_EN_BDO];
               irqErr_q <= wdata_q[CSR_IRQ_EN_ERR];
            end
            und_q  <= und_d;
            ucnt_q <= ucnt_d;
            ovf_q  <= ovf_d;
            crst_q <= ~en_q;
         end
      end

      always_comb begin
         csrRd                     = '0;
         csrRd[ST_ENABLED]         = en_q;
         csrRd[ST_BTI_EMPTY]       = btiEmpty;
         csrRd[ST_BTI_FULL]        = btiFull;
         csrRd[ST_BTO_EMPTY]       = btoEmpty;
         csrRd[ST_BTO_FULL]        = btoFull;
         csrRd[ST_UNDER]           = und_q;
         csrRd[ST_OVER]            = ovf_q;
         csrRd[ST_LEVEL_LSB +: 4]  = 4'(btiLvl);
         csrRd[ST_UCNT_LSB +: 4]   = ucnt_q;
         bdRd                      = '0;
         bdRd[BD_VALID_BIT]        = ~btoEmpty;
         bdRd[BD_LEVEL_LSB +: 4]   = 4'(btoLvl);
         bdRd[MFW-1:0]             = btoHead;
      end

      assign csrRdArr[c]           = csrRd;
      assign bdRdArr[c]            = bdRd;
      assign btiFullV[c]           = btiFull;
      assign btoEmptyV[c]          = btoEmpty;
      assign bd_mf[c*MFW +: MFW]   = btiHead[MFW-1:0];
      assign bd_crc_e[2*c +: 2]    = (mode_q == MODE_CRC4_AUTO) ? crc_e_auto[2*c +: 2]
                                                               : btiHead[MFW +: 2];
      assign bd_valid[c]           = ~btiEmpty;
      assign ctrl_enabled[c]       = en_q;
      assign ctrl_rst[c]           = crst_q;
      assign ctrl_mode[2*c +: 2]   = mode_q;
      assign ctrl_time_src[c]      = tsrc_q;
      assign ctrl_alarm[c]         = alarm_q;
      assign ctrl_loopback[2*c +: 2] = lb_q;
      assign irq[c] = (irqBdo_q & ~btoEmpty) | (irqErr_q & (und_q | ovf_q));
   end

endmodule

// File: tb/tb_e1_wb_tx_bdctl.sv
// Directed bench for e1_wb_tx_bdctl: a table of bus accesses with hand-computed read data,
// followed by hand-written sequences for the multi-cycle queue and sticky corner cases.
module tb_e1_wb_tx_bdctl;

   logic        clk, rst;
   logic        bus_addr_sel, bus_clr, bus_we;
   logic [3:0]  bus_addr;
   logic [15:0] bus_wdata, bus_rdata;
   logic [27:0] bd_mf;
   logic [7:0]  bd_crc_e, ctrl_mode, ctrl_loopback, crc_e_auto;
   logic [3:0]  bd_valid, bd_done, bd_miss, ctrl_enabled, ctrl_rst;
   logic [3:0]  ctrl_time_src, ctrl_alarm, crc_e_ack, irq;
   logic        irq_any;

   int          checks, errors;
   logic [15:0] rd;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  ch;
      logic        lsb;
      logic [15:0] wdata;
      logic [15:0] expRdata;
   } vec_t;

   vec_t vecs [14];

   e1_wb_tx_bdctl dut (
      .clk           (clk),
      .rst           (rst),
      .bus_addr_sel  (bus_addr_sel),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_clr       (bus_clr),
      .bus_we        (bus_we),
      .bd_mf         (bd_mf),
      .bd_crc_e      (bd_crc_e),
      .bd_valid      (bd_valid),
      .bd_done       (bd_done),
      .bd_miss       (bd_miss),
      .ctrl_enabled  (ctrl_enabled),
      .ctrl_rst      (ctrl_rst),
      .ctrl_mode     (ctrl_mode),
      .ctrl_time_src (ctrl_time_src),
      .ctrl_alarm    (ctrl_alarm),
      .ctrl_loopback (ctrl_loopback),
      .crc_e_auto    (crc_e_auto),
      .crc_e_ack     (crc_e_ack),
      .irq           (irq),
      .irq_any       (irq_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mkVec(input string n, input logic we, input logic [2:0] ch,
                                  input logic lsb, input logic [15:0] wd, input logic [15:0] ex);
      vec_t v;
      v.name = n; v.we = we; v.ch = ch; v.lsb = lsb; v.wdata = wd; v.expRdata = ex;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Strobe one cycle, then wait for the registered strobe to take effect.
   task automatic busWrite(input logic [2:0] ch, input logic lsb, input logic [15:0] data);
      @(negedge clk);
      bus_addr_sel = 1'b1; bus_we = 1'b1; bus_addr = {ch, lsb}; bus_wdata = data;
      @(negedge clk);
      bus_addr_sel = 1'b0; bus_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic busRead(input logic [2:0] ch, input logic lsb, output logic [15:0] data);
      @(negedge clk);
      bus_addr_sel = 1'b1; bus_we = 1'b0; bus_addr = {ch, lsb};
      #1 data = bus_rdata;
      @(negedge clk);
      bus_addr_sel = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulseDone(input int ch);
      logic [3:0] expAck;
      expAck = 4'b0001 << ch;
      @(negedge clk);
      bd_done = expAck;
      #1 checkOutput("crc_e_ack", crc_e_ack, expAck);
      @(negedge clk);
      bd_done = 4'b0000;
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [15:0] r;
      if (v.we) busWrite(v.ch, v.lsb, v.wdata);
      else begin
         busRead(v.ch, v.lsb, r);
         checkOutput(v.name, r, v.expRdata);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      bus_addr_sel = 1'b0; bus_clr = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      bd_done = '0; bd_miss = '0; crc_e_auto = 8'hAA;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_ctrl_rst", ctrl_rst, 4'hF);
      checkOutput("rst_bd_valid", bd_valid, 4'h0);
      checkOutput("rst_irq", {irq_any, irq}, 5'h00);
      checkOutput("rst_enabled", ctrl_enabled, 4'h0);
      rst = 1'b0;
      @(negedge clk);

      vecs[0]  = mkVec("csr0_reset",  1'b0, 3'd0, 1'b0, 16'h0000, 16'h000A);
      vecs[1]  = mkVec("wr_csr1",     1'b1, 3'd1, 1'b0, 16'h0001, 16'h0000);
      vecs[2]  = mkVec("csr1_enable", 1'b0, 3'd1, 1'b0, 16'h0000, 16'h000B);
      vecs[3]  = mkVec("wr_csr3",     1'b1, 3'd3, 1'b0, 16'h007F, 16'h0000);
      vecs[4]  = mkVec("csr3_enable", 1'b0, 3'd3, 1'b0, 16'h0000, 16'h000B);
      vecs[5]  = mkVec("wr_csr7",     1'b1, 3'd7, 1'b0, 16'h0001, 16'h0000);
      vecs[6]  = mkVec("csr7_read",   1'b0, 3'd7, 1'b0, 16'h0000, 16'h0000);
      vecs[7]  = mkVec("bd7_read",    1'b0, 3'd7, 1'b1, 16'h0000, 16'h0000);
      vecs[8]  = mkVec("push2_0",     1'b1, 3'd2, 1'b1, 16'h2000, 16'h0000);
      vecs[9]  = mkVec("push2_1",     1'b1, 3'd2, 1'b1, 16'h2001, 16'h0000);
      vecs[10] = mkVec("push2_2",     1'b1, 3'd2, 1'b1, 16'h2002, 16'h0000);
      vecs[11] = mkVec("push2_3",     1'b1, 3'd2, 1'b1, 16'h2003, 16'h0000);
      vecs[12] = mkVec("push2_4",     1'b1, 3'd2, 1'b1, 16'h2004, 16'h0000);
      vecs[13] = mkVec("csr2_full",   1'b0, 3'd2, 1'b0, 16'h0000, 16'h040C);
      for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

      checkOutput("ctrl_enabled", ctrl_enabled, 4'b1010);
      checkOutput("ctrl_rst", ctrl_rst, 4'b0101);
      checkOutput("ctrl_mode", ctrl_mode, 8'hC0);
      checkOutput("ctrl_loopback", ctrl_loopback, 8'hC0);
      checkOutput("ctrl_tsrc_alarm", {ctrl_time_src, ctrl_alarm}, 8'h88);

      // BD-in head feeds the core; four completions move mf 0..3 to BD-out in order.
      checkOutput("bd_valid2", bd_valid, 4'b0100);
      checkOutput("bd_mf2", bd_mf[14 +: 7], 7'd0);
      checkOutput("bd_crc2_stored", bd_crc_e[5:4], 2'b01);
      for (int i = 0; i < 4; i++) pulseDone(2);
      busRead(3'd2, 1'b0, rd); checkOutput("csr2_after_done", rd, 16'h0012);
      busRead(3'd2, 1'b1, rd); checkOutput("bd2_pop0", rd, 16'h8400);
      busRead(3'd2, 1'b1, rd); checkOutput("bd2_pop1", rd, 16'h8301);
      busRead(3'd2, 1'b1, rd); checkOutput("bd2_pop2", rd, 16'h8202);
      busRead(3'd2, 1'b1, rd); checkOutput("bd2_pop3", rd, 16'h8103);
      pulseDone(2);
      busRead(3'd2, 1'b0, rd); checkOutput("csr2_done_empty", rd, 16'h000A);

      // Seventeen misses saturate the counter at 15.
      @(negedge clk);
      bd_miss = 4'b0001;
      repeat (17) @(negedge clk);
      bd_miss = 4'b0000;
      busRead(3'd0, 1'b0, rd); checkOutput("csr0_miss_sat", rd, 16'hF02A);
      checkOutput("irq0_no_en", irq, 4'b0000);
      busWrite(3'd0, 1'b0, 16'h0200);
      checkOutput("irq0_err_en", {irq_any, irq}, 5'b1_0001);
      @(negedge clk);
      bus_addr_sel = 1'b1; bus_we = 1'b1; bus_addr = 4'b0000; bus_wdata = 16'h1200;
      @(negedge clk);
      bus_addr_sel = 1'b0; bus_we = 1'b0; bd_miss = 4'b0001;
      @(negedge clk);
      bd_miss = 4'b0000;
      busRead(3'd0, 1'b0, rd); checkOutput("csr0_miss_vs_clr", rd, 16'h102A);
      busWrite(3'd0, 1'b0, 16'h1200);
      busRead(3'd0, 1'b0, rd); checkOutput("csr0_cleared", rd, 16'h000A);
      checkOutput("irq0_cleared", irq, 4'b0000);

      busWrite(3'd2, 1'b0, 16'h0100);
      checkOutput("irq2_bto_empty", irq, 4'b0000);
      busWrite(3'd2, 1'b1, 16'h0007);
      pulseDone(2);
      checkOutput("irq2_bdo", {irq_any, irq}, 5'b1_0100);

      // Fill BD-out on ch1, then one more completion overflows and is discarded.
      for (int i = 0; i < 4; i++) busWrite(3'd1, 1'b1, 16'(10 + i));
      for (int i = 0; i < 4; i++) pulseDone(1);
      busWrite(3'd1, 1'b1, 16'h000E);
      pulseDone(1);
      busRead(3'd1, 1'b0, rd); checkOutput("csr1_overflow", rd, 16'h0053);
      busWrite(3'd1, 1'b0, 16'h2001);
      busRead(3'd1, 1'b0, rd); checkOutput("csr1_ovf_clr", rd, 16'h0013);

      // Bus pop and completion land on a full BD-out in the same cycle.
      busWrite(3'd1, 1'b1, 16'h000F);
      @(negedge clk);
      bus_addr_sel = 1'b1; bus_we = 1'b0; bus_addr = 4'b0011;
      #1 rd = bus_rdata;
      checkOutput("bd1_pop_race", rd, 16'h840A);
      @(negedge clk);
      bus_addr_sel = 1'b0; bd_done = 4'b0010;
      @(negedge clk);
      bd_done = 4'b0000;
      busRead(3'd1, 1'b0, rd); checkOutput("csr1_race_no_ovf", rd, 16'h0013);
      busRead(3'd1, 1'b1, rd); checkOutput("bd1_race_level", rd, 16'h840B);

      // Auto CRC-E selection follows mode 11; otherwise the stored bits are used.
      busWrite(3'd3, 1'b1, 16'h2005);
      checkOutput("bd_mf3", bd_mf[21 +: 7], 7'd5);
      checkOutput("bd_crc3_auto", bd_crc_e[7:6], 2'b10);
      busWrite(3'd3, 1'b0, 16'h0005);
      checkOutput("bd_crc3_stored", bd_crc_e[7:6], 2'b01);

      @(negedge clk);
      bus_addr_sel = 1'b1; bus_we = 1'b1; bus_clr = 1'b1; bus_addr = 4'b0000; bus_wdata = 16'h0001;
      @(negedge clk);
      bus_addr_sel = 1'b0; bus_we = 1'b0; bus_clr = 1'b0;
      @(negedge clk);
      checkOutput("bus_clr_blocks", ctrl_enabled, 4'b1010);

      busWrite(3'd1, 1'b0, 16'h0000);
      checkOutput("en1_cleared", ctrl_enabled, 4'b1000);
      busRead(3'd1, 1'b1, rd); checkOutput("bd1_kept", rd, 16'h830C);
      checkOutput("ctrl_rst1", ctrl_rst, 4'b0111);

      // Asynchronous reset in the middle of traffic discards everything.
      busWrite(3'd0, 1'b1, 16'h0003);
      checkOutput("pre_rst_valid", bd_valid, 4'b1001);
      checkOutput("pre_rst_irq", irq, 4'b0100);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_valid", bd_valid, 4'b0000);
      checkOutput("midrst_irq", {irq_any, irq}, 5'b0);
      checkOutput("midrst_ctrl_rst", ctrl_rst, 4'hF);
      checkOutput("midrst_ack", crc_e_ack, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      busRead(3'd0, 1'b0, rd); checkOutput("csr0_after_rst", rd, 16'h000A);
      busRead(3'd2, 1'b0, rd); checkOutput("csr2_after_rst", rd, 16'h000A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
